// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle RV32 control FSM:
// state encoding (also exported on state_o) and PC source selects.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [1:0] PC_SEL_SEQ   = 2'd0;
  localparam logic [1:0] PC_SEL_TGT   = 2'd1;
  localparam logic [1:0] PC_SEL_MTVEC = 2'd2;
  localparam logic [1:0] PC_SEL_MEPC  = 2'd3;

  // Writeback PC source: trap entry beats trap return beats a taken redirect.
  function automatic logic [1:0] wb_pc_sel(input logic is_ecall,
                                           input logic is_mret,
                                           input logic pc_write,
                                           input logic taken);
    if (is_ecall)              return PC_SEL_MTVEC;
    else if (is_mret)          return PC_SEL_MEPC;
    else if (pc_write && taken) return PC_SEL_TGT;
    else                       return PC_SEL_SEQ;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_wdog.sv
// Wait-cycle watchdog for the fetch and data-memory handshakes.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   clr         : hold counter at zero (FSM is not in a waiting state)
//   en          : one waiting cycle elapsed without ack
//   expired_c   : this waiting cycle is the MEM_TIMEOUT-th without ack
module multicycle_ctrl_wdog #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Saturating count of consecutive ack-less waiting cycles.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en && (cnt != CW'(MEM_TIMEOUT))) begin
      cnt <= cnt + CW'(1);
    end
  end

  // en already excludes an ack cycle, so a same-cycle ack always wins.
  assign expired_c = en && (cnt >= CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32 core: fetch, decode, execute,
// optional data-memory access, writeback. Generates one-cycle IR/RF/CSR/PC
// write enables and drives request/ack handshakes guarded by a watchdog.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   ifetch_req/ifetch_ack      : instruction fetch handshake
//   ir_we                      : latch instruction (ack cycle in FETCH)
//   dec_*                      : decoder control flags of the held instruction
//   branch_taken               : EXU redirect decision
//   dmem_req/dmem_we/dmem_ack  : data memory handshake
//   rf_we, csr_we, pc_we       : writeback enables (WB only)
//   pc_sel                     : next-PC source (seq/target/mtvec/mepc)
//   stall_err                  : sticky watchdog error (ERR state)
//   state_o                    : current state for debug
// Optional: define MULTICYCLE_CTRL_PERF_EN to add perf_cycle/perf_instret.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifetch_req,
  input  logic        ifetch_ack,
  output logic        ir_we,
  input  logic        dec_reg_write,
  input  logic        dec_pc_write,
  input  logic        dec_mem_valid,
  input  logic        dec_mem_write,
  input  logic        dec_is_ecall,
  input  logic        dec_is_mret,
  input  logic        dec_is_csr,
  input  logic        branch_taken,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic        csr_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        stall_err,
  output logic [2:0]  state_o
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [63:0] perf_cycle,
  output logic [63:0] perf_instret
`endif
);

  state_t state;
  logic   wd_clr;
  logic   wd_en;
  logic   wd_expired_c;

  // Counter runs only while waiting on a handshake; any other state re-arms it.
  assign wd_clr = (state != FETCH) && (state != MEM);
  assign wd_en  = ((state == FETCH) && !ifetch_ack) ||
                  ((state == MEM)   && !dmem_ack);

  multicycle_ctrl_wdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (wd_clr),
    .en        (wd_en),
    .expired_c (wd_expired_c)
  );

  // State register with next-state selection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= FETCH;
        FETCH: begin
          if (ifetch_ack)        state <= DECODE;
          else if (wd_expired_c) state <= ERR;
        end
        DECODE:  state <= EXEC;
        EXEC:    state <= (dec_mem_valid || dec_mem_write) ? MEM : WB;
        MEM: begin
          if (dmem_ack)          state <= WB;
          else if (wd_expired_c) state <= ERR;
        end
        WB:      state <= FETCH;
        ERR:     state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode; handshake qualifiers follow their acks in the same cycle.
  always_comb begin
    ifetch_req = 1'b0;
    ir_we      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 1'b0;
    csr_we     = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = PC_SEL_SEQ;
    stall_err  = 1'b0;
    case (state)
      FETCH: begin
        ifetch_req = 1'b1;
        ir_we      = ifetch_ack;
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_mem_write;
      end
      WB: begin
        pc_we  = 1'b1;
        rf_we  = dec_reg_write;
        csr_we = dec_is_csr | dec_is_ecall;
        pc_sel = wb_pc_sel(dec_is_ecall, dec_is_mret, dec_pc_write, branch_taken);
      end
      ERR:     stall_err = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state;

`ifdef MULTICYCLE_CTRL_PERF_EN
  // Active-cycle and retired-instruction counters, free-running modulo 2^64.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cycle   <= '0;
      perf_instret <= '0;
    end else begin
      if ((state != IDLE) && (state != ERR)) perf_cycle <= perf_cycle + 64'd1;
      if (state == WB) perf_instret <= perf_instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: randomized instruction stream with
// a scoreboard of expected writeback behaviour, plus directed watchdog and
// reset scenarios.
module tb_multicycle_ctrl;

  localparam int unsigned TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ifetch_req, ifetch_ack = 1'b0, ir_we;
  logic       dec_reg_write = 1'b0, dec_pc_write = 1'b0, dec_mem_valid = 1'b0;
  logic       dec_mem_write = 1'b0, dec_is_ecall = 1'b0, dec_is_mret = 1'b0;
  logic       dec_is_csr = 1'b0, branch_taken = 1'b0;
  logic       dmem_req, dmem_we, dmem_ack = 1'b0;
  logic       rf_we, csr_we, pc_we, stall_err;
  logic [1:0] pc_sel;
  logic [2:0] state_o;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [63:0] perf_cycle, perf_instret;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ifetch_req    (ifetch_req),
    .ifetch_ack    (ifetch_ack),
    .ir_we         (ir_we),
    .dec_reg_write (dec_reg_write),
    .dec_pc_write  (dec_pc_write),
    .dec_mem_valid (dec_mem_valid),
    .dec_mem_write (dec_mem_write),
    .dec_is_ecall  (dec_is_ecall),
    .dec_is_mret   (dec_is_mret),
    .dec_is_csr    (dec_is_csr),
    .branch_taken  (branch_taken),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_ack      (dmem_ack),
    .rf_we         (rf_we),
    .csr_we        (csr_we),
    .pc_we         (pc_we),
    .pc_sel        (pc_sel),
    .stall_err     (stall_err),
    .state_o       (state_o)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .perf_cycle    (perf_cycle),
    .perf_instret  (perf_instret)
`endif
  );

  typedef struct {
    bit       rf_we;
    bit       csr_we;
    bit [1:0] pc_sel;
    bit       mem_we;
    int       lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // All request/enable outputs packed, for "everything quiet" checks.
  function automatic logic [31:0] outs_vec();
    return 32'({ifetch_req, ir_we, dmem_req, dmem_we, rf_we, csr_we, pc_we, pc_sel, stall_err});
  endfunction

  task automatic noise();
    ifetch_ack = 1'($urandom);
    dmem_ack   = 1'($urandom);
  endtask

  // Decoder flags for an instruction class:
  // 0 alu, 1 load, 2 store, 3 branch, 4 jal, 5 ecall, 6 mret, 7 csr.
  task automatic set_flags(input int cls, input bit bt);
    {dec_reg_write, dec_pc_write, dec_mem_valid, dec_mem_write,
     dec_is_ecall, dec_is_mret, dec_is_csr} = 7'b0;
    branch_taken = bt;
    case (cls)
      0: dec_reg_write = 1'b1;
      1: begin dec_mem_valid = 1'b1; dec_reg_write = 1'b1; end
      2: dec_mem_write = 1'b1;
      3: dec_pc_write = 1'b1;
      4: begin dec_pc_write = 1'b1; dec_reg_write = 1'b1; branch_taken = 1'b1; end
      5: dec_is_ecall = 1'b1;
      6: dec_is_mret = 1'b1;
      default: begin dec_is_csr = 1'b1; dec_reg_write = 1'b1; end
    endcase
  endtask

  // Drive one instruction: fetch ack after fd idle cycles, memory ack after
  // md idle cycles; acks outside their phase carry random noise.
  task automatic run_instr(input int cls, input int fd, input int md, input bit bt);
    int   guard;
    exp_t e;
    bit   is_mem;
    guard = 0;
    while (state_o != 3'd1 && guard < 20) begin
      noise();
      @(negedge clk);
      guard++;
    end
    if (state_o != 3'd1) begin
      check("fetch_reach", 32'(state_o), 32'd1);
      return;
    end
    for (int i = 0; i <= fd; i++) begin
      ifetch_ack = (i == fd);
      dmem_ack   = 1'($urandom);
      if (i == fd) begin
        set_flags(cls, bt);
        is_mem   = dec_mem_valid | dec_mem_write;
        e.rf_we  = dec_reg_write;
        e.csr_we = dec_is_csr | dec_is_ecall;
        e.mem_we = dec_mem_write;
        if (dec_is_ecall)                      e.pc_sel = 2'd2;
        else if (dec_is_mret)                  e.pc_sel = 2'd3;
        else if (dec_pc_write && branch_taken) e.pc_sel = 2'd1;
        else                                   e.pc_sel = 2'd0;
        e.lat = (fd + 1) + 1 + 1 + (is_mem ? md + 1 : 0) + 1;
        exp_q.push_back(e);
      end else begin
        {dec_reg_write, dec_pc_write, dec_mem_valid, dec_mem_write,
         dec_is_ecall, dec_is_mret, dec_is_csr, branch_taken} = 8'($urandom);
      end
      @(negedge clk);
    end
    repeat (2) begin
      noise();
      @(negedge clk);
    end
    if (is_mem) begin
      for (int j = 0; j <= md; j++) begin
        dmem_ack   = (j == md);
        ifetch_ack = 1'($urandom);
        @(negedge clk);
      end
    end
    noise();
    @(negedge clk);
  endtask

  // Monitor: per-cycle protocol checks and scoreboard pop on each writeback.
  initial begin : monitor
    int         lat;
    int         irc;
    logic [2:0] prev;
    exp_t       e;
    lat = 0;
    irc = 0;
    prev = 3'd0;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (state_o == 3'd1 && prev != 3'd1) begin
          lat = 0;
          irc = 0;
        end
        lat++;
        if (ir_we) irc++;
        check("req_decode", 32'({ifetch_req, dmem_req}), 32'({state_o == 3'd1, state_o == 3'd4}));
        check("ir_we", 32'(ir_we), 32'(ifetch_req & ifetch_ack));
        check("stray_we", 32'({(rf_we | csr_we) & ~pc_we, dmem_we & ~dmem_req, stall_err}), 32'd0);
        if (dmem_req) begin
          if (exp_q.size() == 0) check("dmem_no_txn", 32'(dmem_req), 32'd0);
          else                   check("dmem_we", 32'(dmem_we), 32'(exp_q[0].mem_we));
        end
        if (pc_we) begin
          if (exp_q.size() == 0) begin
            check("wb_no_txn", 32'(pc_we), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("wb_rf_we", 32'(rf_we), 32'(e.rf_we));
            check("wb_csr_we", 32'(csr_we), 32'(e.csr_we));
            check("wb_pc_sel", 32'(pc_sel), 32'(e.pc_sel));
            check("latency", 32'(lat), 32'(e.lat));
            check("ir_we_count", 32'(irc), 32'd1);
          end
        end
      end
      prev = state_o;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL sim_timeout: bench did not finish");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    repeat (3) @(negedge clk);
    #1;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_outs", outs_vec(), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("idle_to_fetch", 32'(state_o), 32'd1);

    // Directed: addi, load/store with 3-cycle ack delay, branches, jal, traps, csr.
    run_instr(0, 0, 0, 1'b0);
    run_instr(1, 0, 3, 1'b0);
    run_instr(2, 0, 3, 1'b0);
    run_instr(3, 0, 0, 1'b0);
    run_instr(3, 0, 0, 1'b1);
    run_instr(4, 0, 0, 1'b1);
    run_instr(5, 0, 0, 1'b1);
    run_instr(6, 0, 0, 1'b1);
    run_instr(7, 0, 0, 1'b0);
    for (int n = 0; n < 200; n++) begin
      run_instr(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'($urandom));
    end
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    @(negedge clk);

    // Fetch timeout: no ack for TO cycles leads to sticky ERR.
    if (state_o != 3'd1) run_instr(0, 0, 0, 1'b0);
    ifetch_ack = 1'b0;
    dmem_ack   = 1'b1;
    for (int k = 0; k < int'(TO); k++) begin
      check("to_wait", 32'(state_o), 32'd1);
      @(negedge clk);
    end
    check("to_err_state", 32'(state_o), 32'd6);
    for (int k = 0; k < 20; k++) begin
      noise();
      #1;
      check("err_sticky", outs_vec(), 32'd1);
      @(negedge clk);
    end
    check("err_state_held", 32'(state_o), 32'd6);

    rst_n = 1'b0;
    @(negedge clk);
    check("err_rst_state", 32'(state_o), 32'd0);
    check("err_rst_outs", outs_vec(), 32'd0);
    rst_n = 1'b1;
    ifetch_ack = 1'b0;
    dmem_ack   = 1'b0;
    @(negedge clk);
    check("refetch", 32'(state_o), 32'd1);

    // Ack on the last permitted wait cycle still wins over the watchdog.
    set_flags(1, 1'b0);
    repeat (int'(TO) - 1) @(negedge clk);
    ifetch_ack = 1'b1;
    #1;
    check("ack_last_ir_we", 32'(ir_we), 32'd1);
    @(negedge clk);
    ifetch_ack = 1'b0;
    check("ack_last_decode", 32'({state_o, stall_err}), 32'({3'd2, 1'b0}));
    @(negedge clk);
    @(negedge clk);
    check("load_mem", 32'(state_o), 32'd4);
    @(negedge clk);

    // Reset during MEM overrides a same-cycle dmem_ack.
    dmem_ack = 1'b1;
    rst_n    = 1'b0;
    #1;
    check("mem_before_rst", 32'(dmem_req), 32'd1);
    @(negedge clk);
    check("mem_rst_state", 32'(state_o), 32'd0);
    check("mem_rst_outs", outs_vec(), 32'd0);
    rst_n    = 1'b1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check("resume_fetch", 32'({state_o, ifetch_req}), 32'({3'd1, 1'b1}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle RV32 core. It sequences instruction fetch, decode, execute, data-memory access and writeback, and generates one-cycle write enables for the IR, register file, CSR file and PC. Its inputs are the decoder's per-instruction control flags and the EXU branch result. Both memory ports use request/ack handshakes, with a wait-timeout watchdog.

Parameters:
MEM_TIMEOUT, 255, maximum wait cycles without ack in FETCH or MEM before entering ERR (>=1).

Ports:
clk  in  1  core clock
rst_n  in  1  reset; synchronous, active-low
ifetch_req  out  1  instruction fetch request
ifetch_ack  in  1  instruction valid from IFU/imem
ir_we  out  1  latch fetched instruction into IR
dec_reg_write  in  1  decoder: instruction writes rd
dec_pc_write  in  1  decoder: jal/jalr/branch
dec_mem_valid  in  1  decoder: load
dec_mem_write  in  1  decoder: store
dec_is_ecall  in  1  decoder: ecall
dec_is_mret  in  1  decoder: mret
dec_is_csr  in  1  decoder: csr instruction with nonzero func3
branch_taken  in  1  EXU: redirect (1 for jal/jalr, compare result for branches)
dmem_req  out  1  data memory request
dmem_we  out  1  store qualifier for dmem_req
dmem_ack  in  1  data memory done
rf_we  out  1  register-file write enable
csr_we  out  1  CSR write enable (csr op, or mepc/mcause on ecall)
pc_we  out  1  PC update enable
pc_sel  out  2  0 pc+4, 1 EXU target, 2 mtvec, 3 mepc
stall_err  out  1  sticky watchdog error
state_o  out  3  current state, for debug/difftest

Behaviour:
- States and encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6.
- rst_n low at a clock edge puts the FSM in IDLE and clears the timeout counter. This happens from any state, including mid-MEM, and overrides any same-cycle ack.
- All outputs are 0 in IDLE. state_o=0.
- IDLE -> FETCH unconditionally on the next edge.
- FETCH: ifetch_req=1 (decoded from state). ir_we = ifetch_ack in this state, same cycle as the ack. On ack -> DECODE.
- DECODE: one cycle, no enables -> EXEC.
- EXEC: one cycle. If dec_mem_valid|dec_mem_write -> MEM, otherwise -> WB.
- MEM: dmem_req=1 and dmem_we=dec_mem_write, held until dmem_ack. On ack -> WB.
- WB: one cycle, then -> FETCH.
  - pc_we=1.
  - rf_we=dec_reg_write.
  - csr_we=dec_is_csr|dec_is_ecall.
  - pc_sel priority: ecall 2 > mret 3 > (dec_pc_write&branch_taken) 1 > 0.
- Decoder flags are sampled only in EXEC/MEM/WB and are stable there because the IR holds.
- ifetch_ack is ignored outside FETCH; dmem_ack is ignored outside MEM.
- Latency with ack in the first request cycle: 4 cycles per non-memory instruction, 5 for load/store.
- Watchdog: the counter clears on entry to FETCH/MEM and increments each waiting cycle without ack. When count reaches MEM_TIMEOUT -> ERR. If ack arrives in the same cycle, the ack wins.
- Counter width is $clog2(MEM_TIMEOUT+1) and it saturates at MEM_TIMEOUT.
- ERR: all request/enable outputs 0, stall_err=1. Exits only via reset.
- Enables are never asserted together with ERR or IDLE.

Optional Feature:
MULTICYCLE_CTRL_PERF_EN:
- Defined: adds outputs perf_cycle[63:0] and perf_instret[63:0], both cleared by reset.
  - perf_cycle increments every cycle not in IDLE/ERR.
  - perf_instret increments in each WB cycle.
  - Both wrap modulo 2^64.
- Undefined: these ports and registers are absent and the remaining behaviour is identical.

Decomposition:
- Package multicycle_ctrl_pkg holds:
  - state typedef enum logic [2:0] with the encodings above;
  - PC_SEL_SEQ/TGT/MTVEC/MEPC 2-bit constants.
- One sub-module, multicycle_ctrl_wdog: the watchdog counter, with clear, count-enable and expired outputs.

Test Plan:
- Reset, then ADDI flags (dec_reg_write=1) with ifetch_ack tied 1 -> state_o sequence 0,1,2,3,5,1. rf_we=1 and pc_we=1 in the WB cycle only, pc_sel=0, ir_we one cycle.
- Load with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, rf_we in the cycle after ack. A store gives the same timing with dmem_we=1 and rf_we=0.
- Branch (dec_pc_write=1):
  - branch_taken=0 -> pc_sel=0, rf_we=0.
  - branch_taken=1 -> pc_sel=1.
  - jal with dec_reg_write=1 -> pc_sel=1, rf_we=1.
- Trap and CSR instructions:
  - ecall -> WB has pc_sel=2, csr_we=1.
  - mret -> pc_sel=3, csr_we=0.
  - csrrw -> csr_we=1, rf_we=1.
- MEM_TIMEOUT=4 with ifetch_ack held 0 -> ERR after 4 FETCH wait cycles, stall_err=1 and sticky for 20 cycles. Ack on the 4th wait cycle -> DECODE, no error.
- rst_n low during MEM with dmem_ack high in the same cycle -> next state IDLE, dmem_req=0, no WB enables. Then FETCH resumes after rst_n returns high.
